// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the memory-port arbiter.
// The package name cpu_pkg is shared with the rest of the CPU.
package cpu_pkg;

  localparam int DATA_W          = 16;
  localparam int TIMEOUT_DEFAULT = 15;

  // The fourth 2-bit code is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// The slave modport is the arbiter's view; the master modport is its environment.
interface mem_port_arbiter_if;
  import cpu_pkg::*;

  logic              req0, req1;
  logic [DATA_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              we0, we1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_sel;
  logic              mem_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
    output ack0, ack1, rdata, err, mem_sel, mem_en, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
    input  ack0, ack1, rdata, err, mem_sel, mem_en, mem_addr, mem_wdata, mem_we, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that did not win last time.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic win,
  output logic any
);

  assign any = req0 | req1;
  assign win = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single 16-bit memory port: one transaction at
// a time, registered port fields, one-cycle ack, timeout with error.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              win, any;

  rr_pick u_rr_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .win        (win),
    .any        (any)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any) begin
          sel_d   = win;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
          we_d    = win ? bus.we1    : bus.we0;
          cnt_d   = 8'd0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // A mem_ack on the last counted cycle still completes successfully.
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          state_d = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        last_grant_d = sel_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // busy and mem_en decode state only, so they carry no input-to-output path.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mem_en    = (state_q == ST_SERVE);
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter for the CPU's single 16-bit memory port. It arbitrates between the instruction-fetch requester (port 0) and the load/store requester (port 1), and drives the 2:1 select that steers address, write data and write enable onto the port. It sequences one memory transaction at a time, returns read data and a one-cycle acknowledge to the winner, and terminates hung transactions with an error after a timeout. It sits between the fetch/execute units and the memory interface.

## Interface
- `DATA_W`, 16, data and address width.
- `TIMEOUT`, 15, maximum cycles in SERVE waiting for `mem_ack`; range 1..255.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: transaction request; held until the matching `ack`.
- `addr0` / `addr1` in 16: request address; stable while `req` is high.
- `wdata0` / `wdata1` in 16: write data.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata` out 16: read data, registered; valid while `ack0` or `ack1` is high.
- `err` out 1: timeout flag, valid with the ack.
- `mem_sel` out 1: registered steering select, 0 = port 0, 1 = port 1.
- `mem_en` out 1: memory transaction strobe.
- `mem_addr` out 16, `mem_wdata` out 16, `mem_we` out 1: registered port fields.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 16: memory read data, valid with `mem_ack`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, SERVE, RESP. Encoding is 2 bits; the fourth code is illegal and recovers to IDLE.
- **IDLE:**
  - Samples `req0` and `req1`.
  - Exactly one request high: that port wins.
  - Both high: the port not equal to `last_grant` wins.
  - On a win:
    - Register `mem_sel`, plus `mem_addr`, `mem_wdata` and `mem_we` from the winner.
    - Clear the timeout counter.
    - Go to SERVE.
  - No request: stay in IDLE, outputs hold.
- **SERVE:**
  - `mem_en` = 1.
  - Request inputs are not resampled; the port fields stay frozen.
  - `mem_ack` = 1: capture `mem_rdata` into `rdata`, set `err` = 0, go to RESP.
  - Otherwise, counter reaches `TIMEOUT` − 1: set `rdata` = 0x0000 and `err` = 1, go to RESP.
  - Otherwise increment the counter.
- **RESP:**
  - `ack[mem_sel]` = 1 for exactly one cycle; `mem_en` = 0.
  - Set `last_grant` = `mem_sel`.
  - Go to IDLE unconditionally.
- **Writes:** `rdata` still updates from `mem_rdata` (don't-care to requesters).
- **Requester rule:** drop `req` in the cycle after `ack`. A `req` still high in IDLE is treated as a new request.
- **Reset:** all outputs 0, state IDLE, `last_grant` = 1 (port 0 wins the first tie), counter 0.
  - Reset during SERVE aborts the transaction; no ack is issued.
  - `mem_en` is low in the cycle after the reset edge.
- **Late `mem_ack`:** `mem_ack` arriving in IDLE or RESP is ignored.

## Timing
- **Minimum transaction:** 3 cycles from the `req` sample edge to IDLE.
  - Edge 0: IDLE→SERVE.
  - Cycle 1: `mem_en` high, `mem_ack` high.
  - Cycle 2: `ack` high.
- **Latency:** `ack` rises 2 + W cycles after the IDLE sample edge, where W = cycles `mem_ack` is late (W = 0 when `mem_ack` arrives in the first SERVE cycle).
- **Timeout:** `ack` with `err` = 1 occurs TIMEOUT + 1 cycles after the sample edge.
- **Back-to-back, both requesting:** grants alternate, 0,1,0,1…; throughput is one transaction per 3 cycles.
- **`mem_ack` on the last counted cycle:** success wins over timeout.
- **Registered outputs:** all outputs are registered except `busy` and `mem_en`, which decode state only, with no combinational path from inputs.

## Structure
- **Package `cpu_pkg`:** state encodings (`ST_IDLE`, `ST_SERVE`, `ST_RESP`), `DATA_W`, and the default `TIMEOUT`.
- **Sub-module `rr_pick`:** combinational; inputs `req0`, `req1`, `last_grant`; outputs `win`, `any`.
- **Field steering:** the 16-bit fields are steered by `win` through in-module 2:1 selects, registered at the IDLE→SERVE edge.

## Test plan
1. Reset, then `req0` alone with `addr0` = 0x0040, read, `mem_ack` in the first SERVE cycle with `mem_rdata` = 0xBEEF → `mem_sel` = 0, `mem_addr` = 0x0040, `ack0` two cycles after the sample edge, `rdata` = 0xBEEF, `err` = 0.
2. `req0` and `req1` held continuously, `mem_ack` always immediate → grant order 0,1,0,1, with one ack every 3 cycles.
3. `req1` write, `addr1` = 0x1234, `wdata1` = 0x00FF, `mem_ack` delayed 4 cycles → `mem_we` = 1 and fields stable for 5 SERVE cycles, `ack1` once, `ack0` never.
4. `TIMEOUT` = 15, `mem_ack` never asserted → `ack` with `err` = 1 and `rdata` = 0x0000 at cycle 16; next request is served normally.
5. Assert `rst` in the 2nd SERVE cycle → no ack, `mem_en` = 0 and `busy` = 0 the next cycle; a tie after reset grants port 0.
6. `mem_ack` pulsed while in IDLE → no state change, no ack.
